// File: rtl/onewire_temp_seq.sv
`default_nettype none
// ============================================================================
// Module   : onewire_temp_seq
// Brief    : DS18B20 measurement sequencer driving a 1-Wire master's byte
//            handshake; runs convert/read, CRC-8 checks the scratchpad and
//            publishes the 16-bit temperature word.
// Revision : 1.0 - initial release
// ============================================================================
module onewire_temp_seq #(
    parameter int CONV_TICKS    = 75,
    parameter int TIMEOUT_TICKS = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick_10ms,
    input  logic        start,
    output logic        ow_rst_req,
    input  logic        ow_rst_done,
    input  logic        ow_presence,
    input  logic        ow_rdy,
    output logic        ow_vld,
    output logic        ow_we,
    output logic [7:0]  ow_wdat,
    input  logic        ow_read,
    input  logic [7:0]  ow_rdat,
    output logic        busy,
    output logic [15:0] temp,
    output logic        temp_vld,
    output logic        crc_err,
    output logic        no_dev
);

    localparam int c_CONV_W = $clog2(CONV_TICKS + 1);
    localparam int c_TMO_W  = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [c_CONV_W-1:0] c_CONV_LAST = c_CONV_W'(CONV_TICKS - 1);
    localparam logic [c_TMO_W-1:0]  c_TMO_LAST  = c_TMO_W'(TIMEOUT_TICKS - 1);

    localparam logic [7:0] c_CMD_SKIP  = 8'hCC;
    localparam logic [7:0] c_CMD_CONVT = 8'h44;
    localparam logic [7:0] c_CMD_RDSP  = 8'hBE;

    localparam logic [3:0] c_IDLE      = 4'd0;
    localparam logic [3:0] c_RST1      = 4'd1;
    localparam logic [3:0] c_SKIP1     = 4'd2;
    localparam logic [3:0] c_CONVT     = 4'd3;
    localparam logic [3:0] c_CONV_WAIT = 4'd4;
    localparam logic [3:0] c_RST2      = 4'd5;
    localparam logic [3:0] c_SKIP2     = 4'd6;
    localparam logic [3:0] c_RDCMD     = 4'd7;
    localparam logic [3:0] c_RDBYTES   = 4'd8;
    localparam logic [3:0] c_CHECK     = 4'd9;
    localparam logic [3:0] c_FAIL      = 4'd10;

    logic [3:0]          r_state;
    logic [3:0]          w_state_nxt;
    logic                r_issued;
    logic                r_seen_low;
    logic [c_TMO_W-1:0]  r_tmo_cnt;
    logic [c_CONV_W-1:0] r_conv_cnt;
    logic [7:0]          r_crc;
    logic [3:0]          r_idx;
    logic [7:0]          r_byte0;
    logic [7:0]          r_byte1;
    logic [15:0]         r_temp;
    logic                r_busy;
    logic                r_temp_vld;
    logic                r_crc_err;
    logic                r_no_dev;

    logic                w_issue;
    logic                w_rd_done;
    logic                w_rst_req;
    logic                w_vld;
    logic                w_we;
    logic [7:0]          w_wdat;
    logic                w_op_state;
    logic                w_tmo;

    // Dallas CRC-8, reflected polynomial, one byte per call (LSB first)
    function automatic logic [7:0] f_crc8(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) c = (c >> 1) ^ 8'h8C;
            else                c = c >> 1;
        end
        return c;
    endfunction

    assign w_op_state = (r_state == c_RST1)  || (r_state == c_RST2)  ||
                        (r_state == c_SKIP1) || (r_state == c_CONVT) ||
                        (r_state == c_SKIP2) || (r_state == c_RDCMD) ||
                        (r_state == c_RDBYTES);
    assign w_tmo      = tick_10ms && (r_tmo_cnt == c_TMO_LAST);

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_rd_done   = 1'b0;
        w_rst_req   = 1'b0;
        w_vld       = 1'b0;
        w_we        = 1'b0;
        w_wdat      = 8'h00;
        case (r_state)
            c_IDLE: begin
                if (start) w_state_nxt = c_RST1;
            end
            c_RST1, c_RST2: begin
                if (!r_issued) begin
                    w_rst_req = 1'b1;
                    w_issue   = 1'b1;
                end else if (ow_rst_done) begin
                    if (!ow_presence)          w_state_nxt = c_FAIL;
                    else if (r_state == c_RST1) w_state_nxt = c_SKIP1;
                    else                        w_state_nxt = c_SKIP2;
                end else if (w_tmo) begin
                    w_state_nxt = c_FAIL;
                end
            end
            c_SKIP1, c_CONVT, c_SKIP2, c_RDCMD: begin
                w_we = 1'b1;
                case (r_state)
                    c_CONVT: w_wdat = c_CMD_CONVT;
                    c_RDCMD: w_wdat = c_CMD_RDSP;
                    default: w_wdat = c_CMD_SKIP;
                endcase
                if (!r_issued) begin
                    if (ow_rdy) begin
                        w_vld   = 1'b1;
                        w_issue = 1'b1;
                    end else if (w_tmo) begin
                        w_state_nxt = c_FAIL;
                    end
                end else if (r_seen_low && ow_rdy) begin
                    case (r_state)
                        c_SKIP1: w_state_nxt = c_CONVT;
                        c_CONVT: w_state_nxt = c_CONV_WAIT;
                        c_SKIP2: w_state_nxt = c_RDCMD;
                        default: w_state_nxt = c_RDBYTES;
                    endcase
                end else if (w_tmo) begin
                    w_state_nxt = c_FAIL;
                end
            end
            c_CONV_WAIT: begin
                if (tick_10ms && (r_conv_cnt == c_CONV_LAST)) w_state_nxt = c_RST2;
            end
            c_RDBYTES: begin
                if (!r_issued) begin
                    if (ow_rdy) begin
                        w_vld   = 1'b1;
                        w_issue = 1'b1;
                    end else if (w_tmo) begin
                        w_state_nxt = c_FAIL;
                    end
                end else if (ow_read) begin
                    w_rd_done = 1'b1;
                    if (r_idx == 4'd8) w_state_nxt = c_CHECK;
                end else if (w_tmo) begin
                    w_state_nxt = c_FAIL;
                end
            end
            c_CHECK: w_state_nxt = c_IDLE;
            c_FAIL:  w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_issued   <= 1'b0;
            r_seen_low <= 1'b0;
            r_tmo_cnt  <= '0;
            r_conv_cnt <= '0;
            r_crc      <= 8'h00;
            r_idx      <= 4'd0;
            r_byte0    <= 8'h00;
            r_byte1    <= 8'h00;
            r_temp     <= 16'h0000;
            r_busy     <= 1'b0;
            r_temp_vld <= 1'b0;
            r_crc_err  <= 1'b0;
            r_no_dev   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            // Result pulses and busy fall land on the same edge that enters IDLE
            r_busy     <= (w_state_nxt != c_IDLE);
            r_temp_vld <= (r_state == c_CHECK) && (r_crc == 8'h00);
            r_crc_err  <= (r_state == c_CHECK) && (r_crc != 8'h00);
            r_no_dev   <= (r_state == c_FAIL);

            if ((w_state_nxt != r_state) || w_rd_done) begin
                r_issued   <= 1'b0;
                r_seen_low <= 1'b0;
            end else if (w_issue) begin
                r_issued   <= 1'b1;
                r_seen_low <= 1'b0;
            end else if (r_issued && !ow_rdy) begin
                r_seen_low <= 1'b1;
            end

            if ((w_state_nxt != r_state) || w_issue || w_rd_done) begin
                r_tmo_cnt <= '0;
            end else if (tick_10ms && w_op_state) begin
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end

            if (r_state != c_CONV_WAIT) begin
                r_conv_cnt <= '0;
            end else if (tick_10ms) begin
                r_conv_cnt <= r_conv_cnt + 1'b1;
            end

            if (r_state == c_IDLE) begin
                r_crc <= 8'h00;
                r_idx <= 4'd0;
            end else if (w_rd_done) begin
                r_crc <= f_crc8(r_crc, ow_rdat);
                r_idx <= r_idx + 4'd1;
                if (r_idx == 4'd0) r_byte0 <= ow_rdat;
                if (r_idx == 4'd1) r_byte1 <= ow_rdat;
            end

            if ((r_state == c_CHECK) && (r_crc == 8'h00)) begin
                r_temp <= {r_byte1, r_byte0};
            end
        end
    end

    // Requests are suppressed while reset is held so an abort never leaks a strobe
    assign ow_rst_req = w_rst_req & ~rst;
    assign ow_vld     = w_vld & ~rst;
    assign ow_we      = w_we;
    assign ow_wdat    = w_wdat;
    assign busy       = r_busy;
    assign temp       = r_temp;
    assign temp_vld   = r_temp_vld;
    assign crc_err    = r_crc_err;
    assign no_dev     = r_no_dev;

endmodule
`default_nettype wire

// File: tb/tb_onewire_temp_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_onewire_temp_seq
// Brief    : Scoreboard bench for onewire_temp_seq with a reactive 1-Wire
//            master model and a reference CRC/temperature model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_onewire_temp_seq;

    localparam int CONV_TICKS    = 75;
    localparam int TIMEOUT_TICKS = 10;
    localparam int TICK_DIV      = 20;
    localparam int K_OK          = 0;
    localparam int K_CRC         = 1;
    localparam int K_NODEV       = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick_10ms = 1'b0;
    logic        start = 1'b0;
    logic        ow_rst_req;
    logic        ow_rst_done = 1'b0;
    logic        ow_presence = 1'b0;
    logic        ow_rdy = 1'b1;
    logic        ow_vld;
    logic        ow_we;
    logic [7:0]  ow_wdat;
    logic        ow_read = 1'b0;
    logic [7:0]  ow_rdat = 8'h00;
    logic        busy;
    logic [15:0] temp;
    logic        temp_vld;
    logic        crc_err;
    logic        no_dev;

    onewire_temp_seq #(
        .CONV_TICKS    (CONV_TICKS),
        .TIMEOUT_TICKS (TIMEOUT_TICKS)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .tick_10ms   (tick_10ms),
        .start       (start),
        .ow_rst_req  (ow_rst_req),
        .ow_rst_done (ow_rst_done),
        .ow_presence (ow_presence),
        .ow_rdy      (ow_rdy),
        .ow_vld      (ow_vld),
        .ow_we       (ow_we),
        .ow_wdat     (ow_wdat),
        .ow_read     (ow_read),
        .ow_rdat     (ow_rdat),
        .busy        (busy),
        .temp        (temp),
        .temp_vld    (temp_vld),
        .crc_err     (crc_err),
        .no_dev      (no_dev)
    );

    typedef struct {
        int          kind;
        logic [15:0] temp;
        int          nwr;
        int          nrd;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e;
    logic [7:0]  wr_seen[$];
    logic [7:0]  exp_wr [4] = '{8'hCC, 8'h44, 8'hCC, 8'hBE};
    logic [7:0]  m_data [9];
    logic        m_presence = 1'b1;
    logic        m_stall = 1'b0;
    logic        m_bp = 1'b0;
    logic        m_we;
    int          m_idx = 0;
    logic [15:0] ref_temp = 16'h0000;
    int          n_checks = 0;
    int          n_fail = 0;
    int          res_cnt = 0;
    int          runs = 0;
    int          n_vld = 0;
    int          mon_nrd = 0;
    int          t_ph = 0;
    int          t_ticks = 0;
    int          kind_got;

    initial forever #5 clk = ~clk;

    initial begin : tick_gen
        forever begin
            repeat (TICK_DIV - 1) @(posedge clk);
            #1 tick_10ms = 1'b1;
            @(posedge clk);
            #1 tick_10ms = 1'b0;
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, got, want);
        end
    endtask

    // Reference CRC over the first n scratchpad bytes
    function automatic logic [7:0] model_crc(input int n);
        logic [7:0] c;
        c = 8'h00;
        for (int b = 0; b < n; b++) begin
            for (int k = 0; k < 8; k++) begin
                if ((c[0] ^ m_data[b][k]) == 1'b1) c = (c >> 1) ^ 8'h8C;
                else                               c = c >> 1;
            end
        end
        return c;
    endfunction

    task automatic set_nominal(input logic [7:0] last);
        m_data = '{8'h50, 8'h05, 8'h4B, 8'h46, 8'h7F, 8'hFF, 8'h0C, 8'h10, 8'h1C};
        m_data[8] = last;
    endtask

    task automatic bp_gap();
        int n;
        if (m_bp) begin
            ow_rdy = 1'b0;
            n = $urandom_range(20, 0);
            repeat (n) begin
                @(posedge clk);
                #1;
            end
        end
        ow_rdy = 1'b1;
    endtask

    // Reactive 1-Wire master
    initial begin : master
        forever begin
            @(negedge clk);
            if (ow_rst_req) begin
                m_idx = 0;
                @(posedge clk);
                repeat ($urandom_range(5, 0)) @(posedge clk);
                #1 ow_rst_done = 1'b1;
                ow_presence = m_presence;
                @(posedge clk);
                #1 ow_rst_done = 1'b0;
                ow_presence = 1'b0;
                bp_gap();
            end else if (ow_vld) begin
                m_we = ow_we;
                @(posedge clk);
                #1 ow_rdy = 1'b0;
                if (m_we && m_stall) begin
                    m_stall = 1'b0;
                    for (int k = 0; k < 11; ) begin
                        @(negedge clk);
                        if (tick_10ms) k++;
                    end
                    @(posedge clk);
                    #1 ow_rdy = 1'b1;
                end else begin
                    repeat ($urandom_range(4, 1)) @(posedge clk);
                    #1;
                    if (m_we) begin
                        ow_rdy = 1'b1;
                        if (m_bp) begin
                            @(posedge clk);
                            #1 bp_gap();
                        end
                    end else begin
                        ow_rdat = (m_idx < 9) ? m_data[m_idx] : 8'hFF;
                        m_idx++;
                        ow_read = 1'b1;
                        @(posedge clk);
                        #1 ow_read = 1'b0;
                        bp_gap();
                    end
                end
            end
        end
    end

    // Monitor and scoreboard
    always @(negedge clk) begin
        if (rst) begin
            wr_seen.delete();
            mon_nrd = 0;
            t_ph = 0;
        end else begin
            if (ow_vld) begin
                n_vld++;
                chk("vld_only_when_rdy", ow_rdy, 1'b1);
                if (ow_we) wr_seen.push_back(ow_wdat);
                else       mon_nrd++;
            end
            if (t_ph == 3) begin
                if (ow_rst_req) begin
                    chk("conv_wait_ticks", t_ticks, CONV_TICKS);
                    t_ph = 0;
                end else if (tick_10ms) begin
                    t_ticks++;
                end
            end else if (t_ph == 2 && ow_rdy) begin
                t_ph = 3;
                t_ticks = 0;
            end else if (t_ph == 1 && !ow_rdy) begin
                t_ph = 2;
            end
            if (ow_vld && ow_we && ow_wdat == 8'h44) t_ph = 1;

            if (temp_vld || crc_err || no_dev) begin
                res_cnt++;
                chk("result_expected", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    kind_got = temp_vld ? K_OK : (crc_err ? K_CRC : K_NODEV);
                    chk("result_kind", kind_got, e.kind);
                    chk("result_onehot", int'(temp_vld) + int'(crc_err) + int'(no_dev), 1);
                    chk("busy_falls_with_result", busy, 1'b0);
                    chk("temp_value", temp, e.temp);
                    chk("write_count", wr_seen.size(), e.nwr);
                    chk("read_count", mon_nrd, e.nrd);
                    for (int i = 0; i < wr_seen.size() && i < 4; i++) begin
                        chk("write_byte", wr_seen[i], exp_wr[i]);
                    end
                end
                wr_seen.delete();
                mon_nrd = 0;
            end
        end
    end

    task automatic run_seq(input logic pres, input logic stall, input logic bp, input int extra);
        exp_t x;
        int   target;
        int   cyc;
        m_presence = pres;
        m_stall    = stall;
        m_bp       = bp;
        if (!pres || stall) begin
            x.kind = K_NODEV;
            x.nwr  = pres ? 1 : 0;
            x.nrd  = 0;
        end else begin
            x.nwr = 4;
            x.nrd = 9;
            if (model_crc(9) == 8'h00) begin
                x.kind   = K_OK;
                ref_temp = {m_data[1], m_data[0]};
            end else begin
                x.kind = K_CRC;
            end
        end
        x.temp = ref_temp;
        exp_q.push_back(x);
        runs++;
        target = res_cnt + 1;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        if (extra > 0) begin
            repeat (extra) @(posedge clk);
            #1 start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
        end
        cyc = 0;
        while (res_cnt < target && cyc < 8000) begin
            @(negedge clk);
            cyc++;
        end
        chk("run_completed", res_cnt >= target, 1'b1);
        if (res_cnt < target) exp_q.delete();
        repeat (30) @(negedge clk);
        chk("idle_after_run", busy, 1'b0);
    endtask

    initial begin : stim
        int k;
        int cyc;
        int vld_before;

        // start coincident with reset must be ignored
        repeat (3) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("reset_outputs", {ow_rst_req, ow_vld, ow_we, ow_wdat, busy, temp, temp_vld, crc_err, no_dev}, 0);
        repeat (5) @(negedge clk);
        chk("start_with_rst_ignored", {busy, ow_rst_req}, 0);

        set_nominal(8'h1C);
        run_seq(1'b1, 1'b0, 1'b0, 0);
        set_nominal(8'h1D);
        run_seq(1'b1, 1'b0, 1'b0, 0);
        run_seq(1'b0, 1'b0, 1'b0, 0);
        set_nominal(8'h1C);
        run_seq(1'b1, 1'b1, 1'b0, 0);
        run_seq(1'b1, 1'b0, 1'b0, 0);
        run_seq(1'b1, 1'b0, 1'b0, 300);

        // Abort in the middle of the scratchpad read
        set_nominal(8'h1C);
        m_presence = 1'b1;
        m_bp = 1'b0;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        k = 0;
        cyc = 0;
        while (k < 4 && cyc < 8000) begin
            @(negedge clk);
            cyc++;
            if (ow_read) k++;
        end
        chk("reads_before_abort", k, 4);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        ref_temp = 16'h0000;
        @(negedge clk);
        chk("abort_outputs", {ow_rst_req, ow_vld, ow_we, ow_wdat, busy, temp, temp_vld, crc_err, no_dev}, 0);
        vld_before = n_vld;
        repeat (100) @(negedge clk);
        chk("no_vld_after_abort", n_vld - vld_before, 0);
        run_seq(1'b1, 1'b0, 1'b0, 0);

        for (int i = 0; i < 9; i++) m_data[i] = 8'hFF;
        run_seq(1'b1, 1'b0, 1'b0, 0);

        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 8; i++) m_data[i] = 8'($urandom);
            m_data[8] = model_crc(8);
            if ($urandom_range(1, 0) == 1) m_data[8] = m_data[8] ^ 8'(1 << $urandom_range(7, 0));
            run_seq(1'b1, 1'b0, 1'b1, 0);
        end
        set_nominal(8'h1C);
        run_seq(1'b1, 1'b0, 1'b1, 0);

        chk("total_results", res_cnt, runs);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/onewire_temp_seq.md
Name: onewire_temp_seq

Overview:
- Command sequencer that sits directly upstream of the 1-Wire master and drives its byte handshake.
- Runs a complete DS18B20 temperature measurement per start request: reset/presence, Skip ROM, Convert T, conversion wait, reset/presence, Skip ROM, Read Scratchpad, then 9 read bytes.
- Checks the Dallas CRC-8 over the scratchpad and presents the 16-bit temperature word to downstream logic (UART formatter or CSR).

Parameters:
- CONV_TICKS, 75, number of tick_10ms pulses to wait for conversion (75 = 750 ms, 12-bit resolution).
- TIMEOUT_TICKS, 10, number of tick_10ms pulses allowed for any single master operation before abort.

Ports:
- clk  in  1  system clock (10 MHz).
- rst  in  1  synchronous active-high reset.
- tick_10ms  in  1  single-cycle strobe every 10 ms.
- start  in  1  single-cycle request; ignored while busy=1.
- ow_rst_req  out  1  single-cycle request to the master for a reset/presence slot.
- ow_rst_done  in  1  single-cycle pulse: reset slot finished.
- ow_presence  in  1  presence result, valid when ow_rst_done=1.
- ow_rdy  in  1  master idle and able to accept a byte operation.
- ow_vld  out  1  single-cycle byte-operation request.
- ow_we  out  1  1 = write ow_wdat, 0 = read; valid with ow_vld.
- ow_wdat  out  8  byte to write; valid with ow_vld.
- ow_read  in  1  single-cycle pulse: ow_rdat holds a received byte.
- ow_rdat  in  8  received byte.
- busy  out  1  sequence in progress.
- temp  out  16  last good scratchpad bytes {byte1, byte0}.
- temp_vld  out  1  single-cycle pulse: temp updated.
- crc_err  out  1  single-cycle pulse: CRC mismatch; temp not updated.
- no_dev  out  1  single-cycle pulse: no presence, or timeout.

Behaviour:
- Reset: every output is 0 (temp = 16'h0000). State = IDLE. CRC, byte index and all counters are cleared. A reset mid-sequence aborts immediately. No further ow_vld or ow_rst_req is issued.
- States and transitions:
  - IDLE -> RST1 on start.
  - RST1 asserts ow_rst_req for 1 cycle, then waits for ow_rst_done.
  - If ow_presence=0, go to FAIL. If ow_presence=1, go to SKIP1 (0xCC) -> CONVT (0x44) -> CONV_WAIT.
  - CONV_WAIT counts CONV_TICKS tick_10ms pulses, then goes to RST2.
  - RST2 behaves as RST1, then SKIP2 (0xCC) -> RDCMD (0xBE) -> RDBYTES.
  - RDBYTES issues 9 reads, then goes to CHECK -> IDLE.
  - FAIL pulses no_dev, then goes to IDLE.
- Byte issue rule: in a write or read state, ow_vld is asserted for exactly 1 cycle on the first cycle where ow_rdy=1. ow_we and ow_wdat are held stable through the operation.
- Write completion: ow_rdy is seen low and then high again. Read completion: an ow_read pulse.
- The next byte issue is no earlier than the cycle after completion.
- RDBYTES captures byte0 and byte1. Each received byte is fed through the CRC-8 (poly x^8+x^5+x^4+1, LSB-first, reflected constant 0x8C, init 0x00), one bit per clock or byte-parallel. The CRC must be settled before CHECK.
- CHECK, CRC residue == 0x00: temp <= {byte1, byte0} and temp_vld pulses 1 cycle.
- CHECK, CRC residue != 0x00: crc_err pulses and temp holds its old value.
- All 9 bytes are 0xFF (bus stuck high, residue nonzero): this is reported as crc_err.
- Timeout: any wait for ow_rdy, ow_rst_done or ow_read exceeding TIMEOUT_TICKS ticks goes to FAIL. The timeout counter restarts at each new operation.
- busy = 1 in every state except IDLE, and falls on the same cycle temp_vld, crc_err or no_dev pulses.
- start while busy is dropped, not queued. start on the same cycle as rst is ignored.
- At most one of temp_vld, crc_err or no_dev pulses per sequence.
- Stray ow_read or ow_rst_done pulses in a state not expecting them are ignored.

Test Plan:
- Nominal: presence=1; master model returns 50 05 4B 46 7F FF 0C 10 1C -> writes observed in order CC 44 CC BE; 75 ticks between 44 completion and the second reset; temp_vld pulse with temp=16'h0550; crc_err=0.
- CRC error: same data with last byte 0x1D -> crc_err pulse, temp keeps previous 16'h0550, busy falls the same cycle.
- No device: ow_presence=0 on the first ow_rst_done -> no_dev pulse; no ow_vld ever asserted; back to IDLE.
- Timeout: master holds ow_rdy=0 after SKIP1 issue for 11 ticks -> no_dev pulse at tick 10 boundary; later start runs normally.
- Start while busy and reset mid-sequence: second start during CONV_WAIT -> ignored, exactly one completion. rst in RDBYTES after 4 bytes -> all outputs 0, no further ow_vld; next start restarts from RST1.
- Handshake backpressure: ow_rdy deasserted randomly 0-20 cycles before each issue -> ow_vld is never asserted while ow_rdy=0, exactly 4 writes + 9 reads per run, result identical to nominal.
